// File: rtl/down_counter_pkg.sv
// Shared types and default parameters for the down_counter timing primitive.
package down_counter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int DEFAULT_WIDTH    = 8;
  localparam int DEFAULT_PRESCALE = 4;

endpackage

// File: rtl/down_counter_prescaler.sv
// Divides enabled cycles by PRESCALE; tick is high on the enabled cycle that
// completes each group of PRESCALE enabled cycles.
module down_counter_prescaler
  import down_counter_pkg::*;
#(
  parameter int PRESCALE = DEFAULT_PRESCALE
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt_reg;

  // PRESCALE==1 makes LAST zero, so every enabled cycle ticks
  assign tick = en && (cnt_reg == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_reg <= '0;
    end else if (en) begin
      cnt_reg <= tick ? '0 : cnt_reg + CW'(1);
    end
  end

endmodule

// File: rtl/down_counter.sv
// Loadable, enable-gated down counter with terminal-count pulse and optional
// auto-reload. Define DOWN_COUNTER_PRESCALE_EN to divide decrements by PRESCALE.
module down_counter
  import down_counter_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int PRESCALE = DEFAULT_PRESCALE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy
);

  state_e           state_reg, state_next;
  logic [WIDTH-1:0] count_reg, count_next;
  logic [WIDTH-1:0] reload_reg, reload_next;
  logic             tc_reg, tc_next;
  logic             busy_reg, busy_next;
  logic             tick;

`ifdef DOWN_COUNTER_PRESCALE_EN
  logic pre_en;
  // The prescaler only advances while a countdown is active
  assign pre_en = en && ((state_reg == RUN) || (state_reg == HOLD));

  down_counter_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (load),
    .en   (pre_en),
    .tick (tick)
  );
`else
  logic unused_prescale;
  assign unused_prescale = (PRESCALE == 0);
  assign tick = en;
`endif

  always_comb begin
    state_next  = state_reg;
    count_next  = count_reg;
    reload_next = reload_reg;
    tc_next     = 1'b0;
    if (load) begin
      count_next  = load_val;
      reload_next = load_val;
      state_next  = (load_val != '0) ? RUN : IDLE;
    end else begin
      case (state_reg)
        RUN, HOLD: begin
          if (!en) begin
            state_next = HOLD;
          end else begin
            state_next = RUN;
            if (tick) begin
              if (count_reg == WIDTH'(1)) begin
                tc_next = 1'b1;
                // Reload skips zero so the period is exactly reload_reg ticks
                if (auto_reload) begin
                  count_next = reload_reg;
                end else begin
                  count_next = '0;
                  state_next = DONE;
                end
              end else begin
                count_next = count_reg - WIDTH'(1);
              end
            end
          end
        end
        default: ;
      endcase
    end
    busy_next = (state_next == RUN) || (state_next == HOLD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      count_reg  <= '0;
      reload_reg <= '0;
      tc_reg     <= 1'b0;
      busy_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      count_reg  <= count_next;
      reload_reg <= reload_next;
      tc_reg     <= tc_next;
      busy_reg   <= busy_next;
    end
  end

  assign count = count_reg;
  assign tc    = tc_reg;
  assign busy  = busy_reg;

endmodule

// File: tb/tb_down_counter.sv
// Directed self-checking bench for down_counter; prints one line per clock step.
module tb_down_counter;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         load;
  logic [W-1:0] load_val;
  logic         en;
  logic         auto_reload;
  logic [W-1:0] count;
  logic         tc;
  logic         busy;

  int checks;
  int errors;

  down_counter #(.WIDTH(W), .PRESCALE(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .load_val    (load_val),
    .en          (en),
    .auto_reload (auto_reload),
    .count       (count),
    .tc          (tc),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  // Advance one edge, then compare count/tc/busy against hand-computed values
  task automatic step(input string tag, input int exp_count, input int exp_tc, input int exp_busy);
    @(posedge clk);
    #1;
    $display("%-10s rst=%0b load=%0b lv=%0d en=%0b ar=%0b -> count=%0d tc=%0b busy=%0b",
             tag, rst, load, load_val, en, auto_reload, count, tc, busy);
    check({tag, ".count"}, int'(count), exp_count);
    check({tag, ".tc"}, int'(tc), exp_tc);
    check({tag, ".busy"}, int'(busy), exp_busy);
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst         = 1'b1;
    load        = 1'b0;
    load_val    = 8'hAA;
    en          = 1'b1;
    auto_reload = 1'b0;
    #1;
    step("reset0", 0, 0, 0);
    step("reset1", 0, 0, 0);
    rst = 1'b0;
    en  = 1'b0;

`ifdef DOWN_COUNTER_PRESCALE_EN
    load = 1'b1; load_val = 8'd2; en = 1'b1;
    step("ps_load", 2, 0, 1);
    load = 1'b0;
    for (int i = 0; i < 3; i++) step("ps_hold2", 2, 0, 1);
    step("ps_dec1", 1, 0, 1);
    for (int i = 0; i < 3; i++) step("ps_hold1", 1, 0, 1);
    step("ps_tc", 0, 1, 0);
    step("ps_done", 0, 0, 0);
`else
    // One-shot countdown from 5; en is ignored on the load edge
    load = 1'b1; load_val = 8'd5; en = 1'b1;
    step("ld5", 5, 0, 1);
    load = 1'b0;
    for (int v = 4; v >= 1; v--) step("dn", v, 0, 1);
    step("tc5", 0, 1, 0);
    for (int i = 0; i < 5; i++) step("done", 0, 0, 0);

    // Auto-reload period of 3
    load = 1'b1; load_val = 8'd3; auto_reload = 1'b1;
    step("ld3", 3, 0, 1);
    load = 1'b0;
    for (int p = 0; p < 3; p++) begin
      step("ar2", 2, 0, 1);
      step("ar1", 1, 0, 1);
      step("ar_tc", 3, 1, 1);
    end

    // Hold then reload mid-run
    load = 1'b1; load_val = 8'd7; auto_reload = 1'b0;
    step("ld7", 7, 0, 1);
    load = 1'b0;
    step("r6", 6, 0, 1);
    step("r5", 5, 0, 1);
    step("r4", 4, 0, 1);
    en = 1'b0;
    for (int i = 0; i < 3; i++) step("hold4", 4, 0, 1);
    en = 1'b1;
    step("res3", 3, 0, 1);
    step("res2", 2, 0, 1);
    load = 1'b1; load_val = 8'd9;
    step("ld9", 9, 0, 1);
    load = 1'b0;
    for (int v = 8; v >= 3; v--) step("dn9", v, 0, 1);

    // Reset mid-run, then a zero load stays idle
    rst = 1'b1;
    step("rst_mid", 0, 0, 0);
    rst = 1'b0;
    load = 1'b1; load_val = 8'd0;
    step("ld0", 0, 0, 0);
    load = 1'b0;
    for (int i = 0; i < 3; i++) step("idle0", 0, 0, 0);

    // Reload value 1: tc stays high continuously, then one-shot finish
    load = 1'b1; load_val = 8'd1; auto_reload = 1'b1;
    step("ld1", 1, 0, 1);
    load = 1'b0;
    step("tc1a", 1, 1, 1);
    step("tc1b", 1, 1, 1);
    auto_reload = 1'b0;
    step("tc1end", 0, 1, 0);
    step("done1", 0, 0, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
